// File: rtl/dt_res_packer.sv
// -----------------------------------------------------------------------------
// dt_res_packer
//
// Scans the 128x128 (16384-pixel) distance-transform result memory after the
// engine finishes. Each 8-bit distance is thresholded to one bit, and the bits
// are packed 16 per word (MSB = lowest pixel address) into a 1024 x 16-bit
// packed-image memory. The block also counts the foreground pixels.
//
// Optional feature (macro DT_MAXD_EN): adds max_dist, the largest distance
// seen in the scan. It is cleared at the start edge and valid when done rises.
//
// Parameters:
//   THRESH   pixel bit = 1 when res_di > THRESH
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     launch pulse, sampled only while busy is low
//   busy      high while a scan is in progress
//   done      high from scan completion until the next accepted start
//   res_rd    result-memory read enable
//   res_addr  result-memory pixel address (14 bits)
//   res_di    result-memory read data for res_addr (combinational read)
//   pk_wr     packed-memory write strobe, one cycle per word
//   pk_addr   packed-memory word address (10 bits)
//   pk_do     packed word, bit 15 = lowest pixel address
//   fg_count  foreground pixel count of the last or current scan (15 bits)
//   max_dist  (DT_MAXD_EN only) largest distance of the scan
// -----------------------------------------------------------------------------
module dt_res_packer #(
  parameter logic [7:0] THRESH = 8'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        pk_wr,
  output logic [9:0]  pk_addr,
  output logic [15:0] pk_do,
  output logic [14:0] fg_count
`ifdef DT_MAXD_EN
  ,
  output logic [7:0]  max_dist
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        res_rd_q, res_rd_d;
  logic [13:0] res_addr_q, res_addr_d;
  logic        pk_wr_q, pk_wr_d;
  logic [9:0]  pk_addr_q, pk_addr_d;
  logic [15:0] pk_do_q, pk_do_d;
  logic [14:0] fg_q, fg_d;
  logic [14:0] sh_q, sh_d;
`ifdef DT_MAXD_EN
  logic [7:0]  max_q, max_d;
`endif

  logic pix_bit;
  logic launch;

  assign pix_bit = (res_di > THRESH);
  // busy is low only in IDLE and in FIN after done has been raised.
  assign launch  = start && !busy_q;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    res_rd_d   = res_rd_q;
    res_addr_d = res_addr_q;
    pk_wr_d    = 1'b0;
    pk_addr_d  = pk_addr_q;
    pk_do_d    = pk_do_q;
    fg_d       = fg_q;
    sh_d       = sh_q;
`ifdef DT_MAXD_EN
    max_d      = max_q;
`endif

    case (state_q)
      SCAN: begin
        sh_d = {sh_q[13:0], pix_bit};
        fg_d = fg_q + {14'd0, pix_bit};
`ifdef DT_MAXD_EN
        if (res_di > max_q) max_d = res_di;
`endif
        // Sixteenth pixel of a word: the 15 buffered bits plus this one form it.
        if (res_addr_q[3:0] == 4'hF) begin
          pk_do_d   = {sh_q, pix_bit};
          pk_addr_d = res_addr_q[13:4];
          pk_wr_d   = 1'b1;
        end
        if (res_addr_q == 14'h3FFF) begin
          res_rd_d = 1'b0;
          state_d  = FIN;
        end else begin
          res_addr_d = res_addr_q + 14'd1;
        end
      end
      FIN: begin
        // First FIN cycle finishes the scan; afterwards done is simply held.
        if (busy_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (launch) begin
      state_d    = SCAN;
      res_rd_d   = 1'b1;
      res_addr_d = 14'd0;
      fg_d       = 15'd0;
      done_d     = 1'b0;
      busy_d     = 1'b1;
`ifdef DT_MAXD_EN
      max_d      = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_rd_q   <= 1'b0;
      res_addr_q <= 14'd0;
      pk_wr_q    <= 1'b0;
      pk_addr_q  <= 10'd0;
      pk_do_q    <= 16'd0;
      fg_q       <= 15'd0;
      sh_q       <= 15'd0;
`ifdef DT_MAXD_EN
      max_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_rd_q   <= res_rd_d;
      res_addr_q <= res_addr_d;
      pk_wr_q    <= pk_wr_d;
      pk_addr_q  <= pk_addr_d;
      pk_do_q    <= pk_do_d;
      fg_q       <= fg_d;
      sh_q       <= sh_d;
`ifdef DT_MAXD_EN
      max_q      <= max_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign res_rd   = res_rd_q;
  assign res_addr = res_addr_q;
  assign pk_wr    = pk_wr_q;
  assign pk_addr  = pk_addr_q;
  assign pk_do    = pk_do_q;
  assign fg_count = fg_q;
`ifdef DT_MAXD_EN
  assign max_dist = max_q;
`endif

endmodule

// File: tb/tb_dt_res_packer.sv
// -----------------------------------------------------------------------------
// Testbench for dt_res_packer. Two instances share one result-memory image:
// u_a uses THRESH=0, u_b uses THRESH=2. A reference model derives the packed
// words, foreground count and maximum distance directly from the image.
// -----------------------------------------------------------------------------
module tb_dt_res_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, sel;
  logic [7:0] mem [16384];

  logic        a_busy, a_done, a_rd, a_wr;
  logic [13:0] a_addr;
  logic [7:0]  a_di;
  logic [9:0]  a_pk_addr;
  logic [15:0] a_pk_do;
  logic [14:0] a_fg;
  logic        b_busy, b_done, b_rd, b_wr;
  logic [13:0] b_addr;
  logic [7:0]  b_di;
  logic [9:0]  b_pk_addr;
  logic [15:0] b_pk_do;
  logic [14:0] b_fg;
`ifdef DT_MAXD_EN
  logic [7:0]  a_max, b_max, s_max;
`endif

  logic        start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign a_di = mem[a_addr];
  assign b_di = mem[b_addr];

  dt_res_packer #(.THRESH(8'd0)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(a_busy), .done(a_done),
    .res_rd(a_rd), .res_addr(a_addr), .res_di(a_di), .pk_wr(a_wr),
    .pk_addr(a_pk_addr), .pk_do(a_pk_do), .fg_count(a_fg)
`ifdef DT_MAXD_EN
    , .max_dist(a_max)
`endif
  );

  dt_res_packer #(.THRESH(8'd2)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(b_busy), .done(b_done),
    .res_rd(b_rd), .res_addr(b_addr), .res_di(b_di), .pk_wr(b_wr),
    .pk_addr(b_pk_addr), .pk_do(b_pk_do), .fg_count(b_fg)
`ifdef DT_MAXD_EN
    , .max_dist(b_max)
`endif
  );

  logic        s_busy, s_done, s_rd, s_wr;
  logic [13:0] s_addr;
  logic [9:0]  s_pk_addr;
  logic [15:0] s_pk_do;
  logic [14:0] s_fg;

  always_comb begin
    s_busy    = sel ? b_busy    : a_busy;
    s_done    = sel ? b_done    : a_done;
    s_rd      = sel ? b_rd      : a_rd;
    s_wr      = sel ? b_wr      : a_wr;
    s_addr    = sel ? b_addr    : a_addr;
    s_pk_addr = sel ? b_pk_addr : a_pk_addr;
    s_pk_do   = sel ? b_pk_do   : a_pk_do;
    s_fg      = sel ? b_fg      : a_fg;
`ifdef DT_MAXD_EN
    s_max     = sel ? b_max     : a_max;
`endif
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  logic [15:0] cap    [1024];
  logic [15:0] exp_w  [1024];
  logic [15:0] prev_w [1024];

  task automatic clear_mem();
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 16384; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 2));
  endtask

  // Runs one complete scan on the selected instance and checks it against the model.
  task automatic run_scan(input logic use_b, input int glitch_cyc);
    int thr, exp_fg, exp_max, nwr, bad_addr, bad_data, consec, done_cyc, last_wr_cyc;
    logic prev_wr, busy_at_done;
    logic [15:0] word;
    thr = use_b ? 2 : 0;
    exp_fg = 0;
    exp_max = 0;
    for (int w = 0; w < 1024; w++) begin
      word = 16'd0;
      for (int j = 0; j < 16; j++) begin
        if (int'(mem[16 * w + j]) > thr) begin
          word[15 - j] = 1'b1;
          exp_fg++;
        end
        if (int'(mem[16 * w + j]) > exp_max) exp_max = int'(mem[16 * w + j]);
      end
      exp_w[w] = word;
    end

    sel = use_b;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("e0_busy", 32'(s_busy), 32'd1);
    chk("e0_done", 32'(s_done), 32'd0);
    chk("e0_fg", 32'(s_fg), 32'd0);
    chk("e0_res_rd", 32'(s_rd), 32'd1);
    chk("e0_res_addr", 32'(s_addr), 32'd0);

    nwr = 0; bad_addr = 0; bad_data = 0; consec = 0;
    done_cyc = -1; last_wr_cyc = -1; prev_wr = 1'b0; busy_at_done = 1'b1;
    for (int cyc = 1; cyc <= 16500; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == glitch_cyc);
      if (s_wr) begin
        if (prev_wr) consec++;
        if (nwr < 1024) begin
          if (s_pk_addr !== 10'(nwr)) bad_addr++;
          if (s_pk_do !== exp_w[nwr]) bad_data++;
          cap[nwr] = s_pk_do;
        end
        nwr++;
        last_wr_cyc = cyc;
      end
      prev_wr = s_wr;
      if (s_done) begin
        done_cyc = cyc;
        busy_at_done = s_busy;
        break;
      end
    end
    start = 1'b0;

    chk("done_cycle", 32'(done_cyc), 32'd16385);
    chk("busy_at_done", 32'(busy_at_done), 32'd0);
    chk("pk_wr_count", 32'(nwr), 32'd1024);
    chk("pk_wr_consecutive", 32'(consec), 32'd0);
    chk("pk_addr_order", 32'(bad_addr), 32'd0);
    chk("pk_do_words", 32'(bad_data), 32'd0);
    chk("last_wr_cycle", 32'(last_wr_cyc), 32'd16384);
    chk("fg_count", 32'(s_fg), 32'(exp_fg));
    chk("fin_res_rd", 32'(s_rd), 32'd0);
    chk("fin_res_addr", 32'(s_addr), 32'd16383);
    chk("fin_pk_addr", 32'(s_pk_addr), 32'd1023);
    chk("fin_pk_do", 32'(s_pk_do), 32'(exp_w[1023]));
`ifdef DT_MAXD_EN
    chk("max_dist", 32'(s_max), 32'(exp_max));
`endif
  endtask

  task automatic chk_reset_vals(input string who);
    chk({who, "_busy"}, 32'(s_busy), 32'd0);
    chk({who, "_done"}, 32'(s_done), 32'd0);
    chk({who, "_res_rd"}, 32'(s_rd), 32'd0);
    chk({who, "_res_addr"}, 32'(s_addr), 32'd0);
    chk({who, "_pk_wr"}, 32'(s_wr), 32'd0);
    chk({who, "_pk_addr"}, 32'(s_pk_addr), 32'd0);
    chk({who, "_pk_do"}, 32'(s_pk_do), 32'd0);
    chk({who, "_fg"}, 32'(s_fg), 32'd0);
`ifdef DT_MAXD_EN
    chk({who, "_max"}, 32'(s_max), 32'd0);
`endif
  endtask

  int stray_wr, stray_busy, diffs;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst_a");
    sel = 1'b1;
    #1;
    chk_reset_vals("rst_b");
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // All-zero image, THRESH=0.
    run_scan(1'b0, 0);
    chk("zero_word0", 32'(cap[0]), 32'd0);

    // Sparse image with a start pulse during SCAN; also a start from FIN.
    mem[0] = 8'd3;
    mem[15] = 8'd1;
    mem[16383] = 8'd255;
    run_scan(1'b0, 3000);
    chk("sparse_word0", 32'(cap[0]), 32'h8001);
    chk("sparse_word1023", 32'(cap[1023]), 32'h0001);
    chk("sparse_fg", 32'(a_fg), 32'd3);
`ifdef DT_MAXD_EN
    chk("sparse_max", 32'(a_max), 32'd255);
`endif

    // THRESH=2 instance, pixels 16..31 = 0,1,2,3,4,0,...,0,9.
    clear_mem();
    mem[17] = 8'd1;
    mem[18] = 8'd2;
    mem[19] = 8'd3;
    mem[20] = 8'd4;
    mem[31] = 8'd9;
    run_scan(1'b1, 0);
    chk("thr2_word1", 32'(cap[1]), 32'h1801);
    chk("thr2_fg", 32'(b_fg), 32'd3);

    // Reset at cycle 5000 of a scan on a random image.
    rand_mem();
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5000) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    stray_wr = 0;
    stray_busy = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (a_wr) stray_wr++;
      if (a_busy) stray_busy++;
    end
    chk("abort_no_pk_wr", 32'(stray_wr), 32'd0);
    chk("abort_stays_idle", 32'(stray_busy), 32'd0);

    // Fresh scan after the abort, then a rescan started from FIN.
    run_scan(1'b0, 0);
    for (int i = 0; i < 1024; i++) prev_w[i] = cap[i];
    run_scan(1'b0, 0);
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (cap[i] !== prev_w[i]) diffs++;
    chk("rescan_identical", 32'(diffs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dt_res_packer.md
Name: dt_res_packer

Overview:
- Reverse of the distance-transform engine's image-load step: scans the 16384-pixel (128x128) result memory after the engine finishes.
- Thresholds each 8-bit distance to one bit and packs 16 pixels per word into a 1024 x 16-bit packed-image memory, using the same MSB-first layout as the source image ROM.
- Also reports the foreground pixel count.
- Sits after the engine, driving the result-memory read port once the engine is done.

Parameters:
- THRESH, 8'd0: pixel bit = 1 when res_di > THRESH, else 0.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  launch pulse; sampled only when not busy
- busy  output  1  high while a scan is in progress
- done  output  1  level; high from scan completion until the next accepted start
- res_rd  output  1  result-memory read enable
- res_addr  output  14  result-memory pixel address
- res_di  input  8  result-memory read data for the current res_addr (combinational read)
- pk_wr  output  1  packed-memory write strobe, one cycle per word
- pk_addr  output  10  packed-memory word address
- pk_do  output  16  packed word; bit 15 = lowest pixel address
- fg_count  output  15  number of pixels with bit = 1 in the last or current scan

Behaviour:
- Reset values: busy=0, done=0, res_rd=0, res_addr=0, pk_wr=0, pk_addr=0, pk_do=0, fg_count=0, internal shift register=0, state=IDLE.
- Reset mid-scan aborts immediately. No further pk_wr until a new start.
- All outputs are registered.
- States:
  - IDLE: waits for start.
  - SCAN: one pixel per cycle.
  - FIN: done held.
- Transitions: IDLE/FIN --start--> SCAN; SCAN --last pixel captured--> FIN.
- start while in SCAN is ignored.
- Start edge E0 (start=1 in IDLE or FIN):
  - res_rd<=1, res_addr<=0, fg_count<=0, done<=0, busy<=1.
- Edge E(k+1), k=0..16383 (address k is on res_addr):
  - b = (res_di > THRESH).
  - shift register <= {sh[14:0], b}.
  - fg_count += b.
  - res_addr <= k+1 for k<16383; res_addr holds 16383 at k=16383.
- When k[3:0]==15 at that edge:
  - pk_do <= {sh[14:0], b}, pk_addr <= k[13:4], pk_wr <= 1.
  - pk_wr drops at the following edge.
  - pk_wr is never high two consecutive cycles.
- At E16384 (last capture):
  - res_rd <= 0, state <= FIN.
  - pk_wr for word 1023 is high during the cycle after E16384.
- At E16385: done <= 1, busy <= 0.
  - Total: 16385 cycles from start edge to done.
- pk_addr and pk_do hold their last values after a write. res_addr holds 16383 in FIN.
- Counter width rule: fg_count max 16384 fits 15 bits, so it has no wrap or saturation.
- start coincident with reset deassertion: start is sampled on the first edge with reset low.

Optional Feature:
- Macro DT_MAXD_EN.
- With the macro defined:
  - Adds output max_dist [7:0] (reset 0, cleared to 0 at the start edge).
  - At each capture edge, max_dist <= res_di when res_di > max_dist.
  - Final value is valid when done rises.
- Without the macro: no max_dist port and no comparator; all other behaviour is identical.

Test Plan:
- All-zero result memory, THRESH=0, start -> 1024 pk_wr pulses, pk_addr 0..1023 in order, every pk_do=16'h0000, fg_count=0, done rises exactly 16385 cycles after the start edge, busy low the same edge.
- Pixel0=3, pixel15=1, rest 0 -> word0 = 16'h8001, all other words 0, fg_count=2; max_dist=3 with DT_MAXD_EN.
- Pixel16383=255, rest 0 -> word 1023 = 16'h0001 on the final pk_wr, one cycle before done; fg_count=1; max_dist=255.
- THRESH=2, pixels 16..31 = 0,1,2,3,4,0,...,0,9 -> word1 = 16'h1801, fg_count=3.
- Reset asserted at cycle 5000 of a scan -> all outputs at reset values, no pk_wr afterwards. Fresh start -> full 16385-cycle scan with correct words.
- start pulsed during SCAN -> ignored, with no timing change. start in FIN -> done drops at the start edge, fg_count clears, rescan produces identical output.
